seg7_display_arbiter: RTL and testbench
=======================================

# seg7_display_arbiter

Shares the board's single 4-digit seven-segment display between two requesters, such as the stopwatch counter and a status/message source. It owns the digit-scan timing and grants the display with a req/gnt handshake, using round-robin arbitration and a minimum hold time. It snapshots the granted requester's 4-nibble code once per scan frame and drives the active-low anode and segment pins directly.

## Interface
- SCAN_DIV, 10000: clk cycles per digit slot; legal range ≥ 2.
- MIN_HOLD, 4: minimum full scan frames a grant is held before it can be preempted; legal range ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high.
- req  in  2  level request per requester; bit 0 = requester 0.
- code0  in  16  requester 0 codes; [15:12] = digit3 (leftmost) … [3:0] = digit0.
- code1  in  16  requester 1 codes, same layout.
- gnt  out  2  one-hot grant, or 2'b00 when idle.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- DIGIT  out  4  active-low anodes; bit 0 = digit0 (rightmost).
- DISPLAY  out  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Scan: a slot counter counts 0..SCAN_DIV-1. At wrap, the slot index advances 0→1→2→3→0.
- Anode per slot: DIGIT = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for slots 0–3.
- Frame boundary: the cycle the slot counter wraps with slot index 3. frame_tick pulses that cycle.
- FSM states: IDLE, OWN0, OWN1. State changes are evaluated only at frame boundaries.
- IDLE: if any req bit is set, grant per the round-robin pointer. The pointer favours the requester not most recently granted; after reset it favours requester 0. If only one bit is set, grant that requester.
- OWNx, req[x] dropped: go to OWN of the other requester if it is requesting, else IDLE.
- OWNx, req[x] held, other requester requesting, hold counter ≥ MIN_HOLD: switch to the other requester (preemption).
- OWNx, otherwise: stay in OWNx. The hold counter increments per frame and saturates at MIN_HOLD. It clears on every grant change.
- Snapshot: at each frame boundary, after arbitration, latch the new owner's code into a 16-bit frame buffer. In IDLE, latch 16'hDDDD (all dashes). No mid-frame tearing.
- Decode of the buffered nibble for the current slot:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
  - A:0001100 (P), B:1011100 (up), C:1100011 (down), D:0111111 (-)
  - E, F: 1111111 (blank)
- Simultaneous events:
  - Both req rise together in IDLE: the round-robin pointer decides.
  - Owner drops req in the same frame the other requester raises it: hand over directly, no IDLE frame.
- Reset mid-frame: everything returns to reset values immediately. The partially scanned frame is discarded.

## Timing
- Reset values:
  - gnt = 2'b00, frame_tick = 0, DIGIT = 4'b1110, DISPLAY = 7'b1111111.
  - slot counter = 0, slot index = 0, frame buffer = 16'hDDDD, state = IDLE, hold counter = 0, pointer → requester 0.
- gnt, state, and frame buffer update on the clk edge at the frame boundary. gnt is registered and is valid the cycle after frame_tick.
- Requester latency: from req assertion to gnt, at most one frame (4·SCAN_DIV cycles) when uncontested.
- DIGIT and DISPLAY are registered. They change together on slot-wrap edges only, so there is no ghosting skew.
- A req pulse shorter than a frame that does not span a boundary is never seen. Requesters must hold req until gnt is set.

## Configuration
- SEG7_ARB_LEAD_BLANK_EN defined: leading-zero blanking on digit2 then digit1.
  - Digit2 is blanked if its nibble is 0.
  - Digit1 is blanked if it is 0 and digit2 was blanked.
  - Digit3 and digit0 are never blanked.
  - Blanking is evaluated on the frame buffer.
- Not defined: all nibbles decode literally; 0 shows as "0".

## Test plan
Bench parameters: SCAN_DIV=4, MIN_HOLD=2.
- Reset: assert rst_n mid-frame → the next cycle shows gnt=00, DIGIT=1110, DISPLAY=1111111. After the first frame, all slots show 0111111.
- Single requester: req=01, code0=16'hB123 → gnt=01 after the next frame_tick. Slots 0–3 show 0110000, 0100100, 1111001, 1011100, each held for 4 cycles.
- Contention: req=11 from IDLE → gnt=01. After 2 frames gnt=10; after 2 more frames gnt=01. Each grant holds for exactly 2 frames.
- Release handover: with gnt=01, drop req[0] while req[1]=1 → gnt=10 at the next boundary with no IDLE frame. Then drop req[1] → gnt=00 and dashes shown.
- Snapshot: change code0 mid-frame → the display is unchanged until the next frame_tick, then shows the new values.
- Leading-blank, with SEG7_ARB_LEAD_BLANK_EN: code0=16'hB005 → digits 2 and 1 blank, digit0 shows 0010010. Without the macro → 1000000 on digits 2 and 1.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Round-robin owner of the shared 4-digit seven-segment display, with a per-frame code snapshot.
// Optional build macro SEG7_ARB_LEAD_BLANK_EN enables leading-zero blanking on digit2/digit1.
module seg7_display_arbiter #(
  parameter int SCAN_DIV = 10000,
  parameter int MIN_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] code0,
  input  logic [15:0] code1,
  output logic [1:0]  gnt,
  output logic        frame_tick,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  localparam int CNT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(MIN_HOLD - 1);
  localparam logic [15:0]       DASHES   = 16'hDDDD;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  slot_cnt;
  logic [1:0]        slot_idx;
  logic [1:0]        idx_nxt;
  logic              slot_wrap;
  logic              frame_end;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              ptr;
  logic [15:0]       fbuf;
  logic [15:0]       fbuf_nxt;
  logic [15:0]       src;
  logic [3:0]        nib;
  logic              blank;
  logic [3:0]        digit_p1;
  logic [6:0]        seg_p1;

  function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic blk);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001100;
      4'hB: s = 7'b1011100;
      4'hC: s = 7'b1100011;
      4'hD: s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return blk ? 7'b1111111 : s;
  endfunction

  function automatic logic [3:0] anode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Scan timing
  assign slot_wrap  = (slot_cnt == CNT_LAST);
  assign frame_end  = slot_wrap && (slot_idx == 2'd3);
  assign frame_tick = frame_end;
  assign idx_nxt    = slot_idx + 2'd1;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      slot_cnt <= '0;
      slot_idx <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      slot_idx <= idx_nxt;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // The frame now ending counts toward the hold, so a grant lasts exactly MIN_HOLD frames when contested.
  assign hold_done = (hold_cnt >= HOLD_PRE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (req == 2'b11)  state_nxt = ptr ? OWN1 : OWN0;
          else if (req[0])   state_nxt = OWN0;
          else if (req[1])   state_nxt = OWN1;
        end
        OWN0: begin
          if (!req[0])                  state_nxt = req[1] ? OWN1 : IDLE;
          else if (req[1] && hold_done) state_nxt = OWN1;
        end
        OWN1: begin
          if (!req[1])                  state_nxt = req[0] ? OWN0 : IDLE;
          else if (req[0] && hold_done) state_nxt = OWN0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0:    gnt = 2'b01;
      OWN1:    gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hold_cnt <= '0;
      ptr      <= 1'b0;
    end else if (frame_end) begin
      if (state_nxt != state)
        hold_cnt <= '0;
      else if ((state != IDLE) && (hold_cnt != HOLD_MAX))
        hold_cnt <= hold_cnt + 1'b1;
      case (state_nxt)
        OWN0:    ptr <= 1'b1;
        OWN1:    ptr <= 1'b0;
        default: ptr <= ptr;
      endcase
    end
  end

  // Frame snapshot
  always_comb begin
    case (state_nxt)
      OWN0:    fbuf_nxt = code0;
      OWN1:    fbuf_nxt = code1;
      default: fbuf_nxt = DASHES;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)          fbuf <= DASHES;
    else if (frame_end) fbuf <= fbuf_nxt;
  end

  // Digit select for the slot about to start; the new snapshot applies from its first slot.
  assign src = frame_end ? fbuf_nxt : fbuf;

  always_comb begin
    case (idx_nxt)
      2'd0:    nib = src[3:0];
      2'd1:    nib = src[7:4];
      2'd2:    nib = src[11:8];
      default: nib = src[15:12];
    endcase
  end

`ifdef SEG7_ARB_LEAD_BLANK_EN
  assign blank = ((idx_nxt == 2'd2) && (src[11:8] == 4'h0)) ||
                 ((idx_nxt == 2'd1) && (src[11:8] == 4'h0) && (src[7:4] == 4'h0));
`else
  assign blank = 1'b0;
`endif

  // Pin registers: anode and segments move together on slot wraps
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      digit_p1 <= 4'b1110;
      seg_p1   <= 7'b1111111;
    end else if (slot_wrap) begin
      digit_p1 <= anode(idx_nxt);
      seg_p1   <= seg_decode(nib, blank);
    end
  end

  assign DIGIT   = digit_p1;
  assign DISPLAY = seg_p1;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scoreboard bench for seg7_display_arbiter: frame-level reference model feeds a per-cycle expectation queue.
module tb_seg7_display_arbiter;
  localparam int SCAN_DIV = 4;
  localparam int MIN_HOLD = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] code0, code1;
  logic [1:0]  gnt;
  logic        frame_tick;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  seg7_display_arbiter #(.SCAN_DIV(SCAN_DIV), .MIN_HOLD(MIN_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code0(code0), .code1(code1),
    .gnt(gnt), .frame_tick(frame_tick), .DIGIT(DIGIT), .DISPLAY(DISPLAY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] gnt;
    logic       tick;
    logic [3:0] dig;
    logic [6:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release, owner (-1 idle), frames held, favoured requester
  int          n;
  int          owner;
  int          frames;
  int          pref;
  logic [15:0] fb;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001100, 7'b1011100,
          7'b1100011, 7'b0111111, 7'b1111111, 7'b1111111};
    return t[v];
  endfunction

  function automatic logic [6:0] shown(input logic [15:0] b, input int slot);
    logic [3:0] v;
    v = b[slot*4 +: 4];
`ifdef SEG7_ARB_LEAD_BLANK_EN
    if (slot == 2 && b[11:8] == 4'h0) return 7'b1111111;
    if (slot == 1 && b[11:8] == 4'h0 && b[7:4] == 4'h0) return 7'b1111111;
`endif
    return seg_of(v);
  endfunction

  task automatic model_reset();
    n = 0; owner = -1; frames = 0; pref = 0; fb = 16'hDDDD;
  endtask

  task automatic arbitrate();
    int nxt;
    int other;
    nxt = owner;
    if (owner < 0) begin
      if (req == 2'b11) nxt = pref;
      else if (req[0])  nxt = 0;
      else if (req[1])  nxt = 1;
    end else begin
      frames = frames + 1;
      other  = 1 - owner;
      if (!req[owner])                          nxt = req[other] ? other : -1;
      else if (req[other] && frames >= MIN_HOLD) nxt = other;
    end
    if (nxt != owner) begin
      frames = 0;
      if (nxt >= 0) pref = 1 - nxt;
    end
    owner = nxt;
    fb = (owner == 0) ? code0 : (owner == 1) ? code1 : 16'hDDDD;
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      e = '{gnt: 2'b00, tick: 1'b0, dig: 4'b1110, disp: 7'b1111111};
    end else begin
      n++;
      if (n % FRAME == 0) arbitrate();
      e.gnt  = (owner < 0) ? 2'b00 : 2'(1 << owner);
      e.tick = ((n % FRAME) == FRAME - 1);
      e.dig  = ~(4'b0001 << ((n / SCAN_DIV) % 4));
      e.disp = (n < SCAN_DIV) ? 7'b1111111 : shown(fb, (n / SCAN_DIV) % 4);
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req_v, $time);
    end
  endtask

  task automatic mid_frame_reset();
    int guard;
    guard = 0;
    while ((n % FRAME) != 7 && guard < 2 * FRAME) begin cycle(); guard++; end
    @(negedge clk);
    #1 rst_n = 1'b1;
    run(3);
    rst_n = 1'b0;
    model_reset();
  endtask

  // Monitor: one expectation per clock, sampled on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",        16'(gnt),        16'(e.gnt));
        check("frame_tick", 16'(frame_tick), 16'(e.tick));
        check("DIGIT",      16'(DIGIT),      16'(e.dig));
        check("DISPLAY",    16'(DISPLAY),    16'(e.disp));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int guard;
    rst_n = 1'b0; req = 2'b00; code0 = 16'h0000; code1 = 16'h0000;
    model_reset();
    #2 rst_n = 1'b1;
    run(3);
    rst_n = 1'b0;
    model_reset();

    // Idle: dashes everywhere after the first frame
    run(2 * FRAME);

    // Contention from idle, pointer starts at requester 0
    code0 = 16'h1234; code1 = 16'h5678;
    req = 2'b11;
    run(6 * FRAME + 3);

    // Release handover while requester 0 owns
    guard = 0;
    while (owner != 0 && guard < 4 * FRAME) begin cycle(); guard++; end
    run(5);
    req = 2'b10;
    run(2 * FRAME);
    req = 2'b00;
    run(2 * FRAME);

    // Single requester, then a mid-frame code change
    code0 = 16'hB123; req = 2'b01;
    run(3 * FRAME);
    run(6);
    code0 = 16'h4567;
    run(2 * FRAME);

    // Zero digits (blanked only when the build enables it)
    code0 = 16'hB005;
    run(2 * FRAME);
    code0 = 16'h9000;
    run(2 * FRAME);

    mid_frame_reset();
    run(FRAME + 2);

    // Randomized traffic
    for (int i = 0; i < 60 * FRAME; i++) begin
      if ($urandom_range(0, 9) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) code0 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) code1 = 16'($urandom);
      if (i == 30 * FRAME) mid_frame_reset();
      cycle();
    end

    @(negedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
